// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: valid/ready operand handshake plus
// the one-cycle out_valid result strobe.
interface seq_alu_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic [2:0]            ctrl;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] result;
   logic                  overflow;

   modport master (
      output in_valid, A, B, ctrl,
      input  in_ready, out_valid, result, overflow
   );

   modport slave (
      input  in_valid, A, B, ctrl,
      output in_ready, out_valid, result, overflow
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle picoMIPS ALU: pass, add, Q1.(W-1) shift-add multiply and MAC.
// Define SEQ_ALU_SAT_EN to clamp overflowing add/multiply/MAC results.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | one shift-add step per cycle, W steps
// FIN   | register result/overflow, pulse out_valid
module seq_alu #(
   parameter int DATA_WIDTH = 8
) (
   input logic     clk,
   input logic     rst,
   seq_alu_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int W2 = 2 * W;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_MAC = 3'b110;
   localparam logic [2:0] OP_CLR = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, b_q, acc_q, acc_d, result_q;
   logic [2:0]      op_q;
   logic [W2-1:0]   prod_q, mcand_q;
   logic [W-1:0]    mplier_q;
   logic [CW-1:0]   cnt_q;
   logic            out_valid_q, overflow_q;
   logic            accept, is_mul;

   logic [W-1:0]    sum, frac, mac_sum, raw_res, res_d;
   logic            add_ovf, frac_ovf, mac_add_ovf, ovf_d;

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.overflow  = overflow_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign is_mul = (bus.ctrl == OP_MUL) || (bus.ctrl == OP_MAC);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = is_mul ? MUL : FIN;
         MUL:     if (cnt_q == LAST) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fractional slice of the 2W-bit product; top two bits differ only for min*min.
   assign frac     = prod_q[W2-2:W-1];
   assign frac_ovf = prod_q[W2-1] ^ prod_q[W2-2];

   assign sum         = a_q + b_q;
   assign add_ovf     = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
   assign mac_sum     = acc_q + frac;
   assign mac_add_ovf = (acc_q[W-1] == frac[W-1]) && (mac_sum[W-1] != acc_q[W-1]);

   always_comb begin
      raw_res = b_q;
      ovf_d   = 1'b0;
      case (op_q)
         OP_ADD: begin raw_res = sum;     ovf_d = add_ovf;                end
         OP_MUL: begin raw_res = frac;    ovf_d = frac_ovf;               end
         OP_MAC: begin raw_res = mac_sum; ovf_d = frac_ovf | mac_add_ovf; end
         OP_CLR: begin raw_res = '0;      ovf_d = 1'b0;                   end
         default: ;
      endcase
   end

`ifdef SEQ_ALU_SAT_EN
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   logic sat_op, neg_d;

   // A sliced-product overflow is always +2^(W-1), so the true MAC sum is non-negative.
   always_comb begin
      sat_op = 1'b0;
      neg_d  = 1'b0;
      case (op_q)
         OP_ADD: begin sat_op = 1'b1; neg_d = a_q[W-1];                 end
         OP_MUL: begin sat_op = 1'b1; neg_d = prod_q[W2-1];             end
         OP_MAC: begin sat_op = 1'b1; neg_d = !frac_ovf && acc_q[W-1]; end
         default: ;
      endcase
      res_d = (sat_op && ovf_d) ? (neg_d ? MINV : MAXV) : raw_res;
   end
`else
   assign res_d = raw_res;
`endif

   always_comb begin
      acc_d = acc_q;
      if (op_q == OP_MAC) acc_d = res_d;
      if (op_q == OP_CLR) acc_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         acc_q       <= '0;
         prod_q      <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            op_q     <= bus.ctrl;
            prod_q   <= '0;
            mcand_q  <= {{W{bus.A[W-1]}}, bus.A};
            mplier_q <= bus.B;
            cnt_q    <= '0;
         end
         if (state_q == MUL) begin
            // Multiplier sign bit carries weight -2^(W-1): subtract on the last step.
            if (mplier_q[0])
               prod_q <= (cnt_q == LAST) ? prod_q - mcand_q : prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
         end
         if (state_q == FIN) begin
            result_q    <= res_d;
            overflow_q  <= ovf_d;
            out_valid_q <= 1'b1;
            acc_q       <= acc_d;
         end
      end
   end
endmodule
